// File: rtl/bypass_network.sv
// EX-stage operand bypass network with a short retired-writeback history and a
// single-cycle load-use stall controller.
module bypass_network #(
  parameter int          XLEN    = 32,
  parameter int          NSRC    = 2,
  parameter int          HIST    = 2,
  parameter int          REGW    = 5,
  parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_busy,
  input  logic                 id_valid,
  input  logic [NSRC*REGW-1:0] id_rs,
  input  logic                 idex_valid,
  input  logic                 idex_is_load,
  input  logic [REGW-1:0]      idex_rd,
  input  logic [NSRC*REGW-1:0] ex_rs,
  input  logic [NSRC*XLEN-1:0] ex_rf_data,
  input  logic                 exmem_valid,
  input  logic                 exmem_is_load,
  input  logic [REGW-1:0]      exmem_rd,
  input  logic [XLEN-1:0]      exmem_data,
  input  logic                 memwb_valid,
  input  logic [REGW-1:0]      memwb_rd,
  input  logic [XLEN-1:0]      memwb_data,
  output logic [NSRC*XLEN-1:0] ex_opnd,
  output logic [NSRC*2-1:0]    ex_src_sel,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 fwd_err,
  output logic [15:0]          stall_cnt
);

  localparam logic [1:0] SEL_IDEX  = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_HIST  = 2'b11;

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t            state_reg;
  logic [15:0]       stall_cnt_reg;
  logic              fwd_err_reg;
  logic [HIST-1:0]   hist_valid_reg;
  logic [REGW-1:0]   hist_rd_reg   [HIST];
  logic [XLEN-1:0]   hist_data_reg [HIST];

  logic [NSRC-1:0]   exmem_hit;
  logic [NSRC-1:0]   id_rs_match;
  logic              hazard;

  genvar gi;

  // Operand resolution: lowest-priority source assigned first, so later
  // assignments override (history oldest..newest, then MEM/WB, then EX/MEM).
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_opnd
      logic [REGW-1:0] rs;
      logic [XLEN-1:0] opnd_next;
      logic [1:0]      sel_next;
      logic            memwb_hit;

      assign rs            = ex_rs[gi*REGW +: REGW];
      assign exmem_hit[gi] = exmem_valid && (exmem_rd == rs) && (rs != '0);
      assign memwb_hit     = memwb_valid && (memwb_rd == rs) && (rs != '0);

      always_comb begin
        opnd_next = ex_rf_data[gi*XLEN +: XLEN];
        sel_next  = SEL_IDEX;
        if (rs != '0) begin
          for (int h = HIST - 1; h >= 0; h--) begin
            if (hist_valid_reg[h] && (hist_rd_reg[h] == rs)) begin
              opnd_next = hist_data_reg[h];
              sel_next  = SEL_HIST;
            end
          end
        end
        if (memwb_hit) begin
          opnd_next = memwb_data;
          sel_next  = SEL_MEMWB;
        end
        if (exmem_hit[gi]) begin
          opnd_next = exmem_data;
          sel_next  = SEL_EXMEM;
        end
      end

      assign ex_opnd[gi*XLEN +: XLEN] = opnd_next;
      assign ex_src_sel[gi*2 +: 2]    = sel_next;
    end

    for (gi = 0; gi < NSRC; gi++) begin : g_hazard
      assign id_rs_match[gi] = (id_rs[gi*REGW +: REGW] == idex_rd);
    end
  endgenerate

  assign hazard = id_valid && idex_valid && idex_is_load &&
                  (idex_rd != '0) && (|id_rs_match);

  // The hazard is ignored in LU_STALL so each load costs exactly one bubble.
  assign stall_id  = !rst && (state_reg == RUN) && hazard;
  assign bubble_ex = stall_id;
  assign fwd_err   = fwd_err_reg;
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      stall_cnt_reg  <= 16'd0;
      fwd_err_reg    <= 1'b0;
      hist_valid_reg <= '0;
    end else if (!mem_busy) begin
      case (state_reg)
        RUN:      state_reg <= hazard ? LU_STALL : RUN;
        LU_STALL: state_reg <= RUN;
        default:  state_reg <= RUN;
      endcase
      if (stall_id && (stall_cnt_reg != CNT_SAT))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      // A load result is not available in EX/MEM; forwarding it is a pipeline bug.
      if (exmem_is_load && (|exmem_hit))
        fwd_err_reg <= 1'b1;
      hist_valid_reg[0] <= memwb_valid && (memwb_rd != '0);
      for (int h = 1; h < HIST; h++)
        hist_valid_reg[h] <= hist_valid_reg[h-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !mem_busy) begin
      hist_rd_reg[0]   <= memwb_rd;
      hist_data_reg[0] <= memwb_data;
      for (int h = 1; h < HIST; h++) begin
        hist_rd_reg[h]   <= hist_rd_reg[h-1];
        hist_data_reg[h] <= hist_data_reg[h-1];
      end
    end
  end

endmodule

// File: tb/tb_bypass_network.sv
// Self-checking bench for bypass_network: vector table, directed corner cases,
// and randomized traffic against a write-log reference model.
module tb_bypass_network;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int HIST = 2;
  localparam int REGW = 5;
  // Short saturation ceiling so the counter limit is reachable in few cycles.
  localparam logic [15:0] SAT = 16'd20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, mem_busy, id_valid;
  logic [NSRC*REGW-1:0] id_rs, ex_rs;
  logic                 idex_valid, idex_is_load;
  logic [REGW-1:0]      idex_rd, exmem_rd, memwb_rd;
  logic [NSRC*XLEN-1:0] ex_rf_data, ex_opnd;
  logic                 exmem_valid, exmem_is_load, memwb_valid;
  logic [XLEN-1:0]      exmem_data, memwb_data;
  logic [NSRC*2-1:0]    ex_src_sel;
  logic                 stall_id, bubble_ex, fwd_err;
  logic [15:0]          stall_cnt;

  bypass_network #(.XLEN(XLEN), .NSRC(NSRC), .HIST(HIST), .REGW(REGW), .CNT_SAT(SAT)) dut (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .id_valid(id_valid), .id_rs(id_rs),
    .idex_valid(idex_valid), .idex_is_load(idex_is_load), .idex_rd(idex_rd),
    .ex_rs(ex_rs), .ex_rf_data(ex_rf_data),
    .exmem_valid(exmem_valid), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .memwb_valid(memwb_valid), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .ex_opnd(ex_opnd), .ex_src_sel(ex_src_sel),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .fwd_err(fwd_err), .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per-register log of the newest retired write, stamped with
  // the number of history shifts performed so far.
  int          sh = 0;
  int          rst_idx = 0;
  int          cap_idx [32];
  logic [31:0] cap_data [32];
  bit          m_in_lu = 0;
  int          m_cnt = 0;
  bit          m_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_hazard();
    bit hit = 0;
    for (int j = 0; j < NSRC; j++)
      if (id_rs[j*REGW +: REGW] == idex_rd) hit = 1;
    return id_valid && idex_valid && idex_is_load && (idex_rd != 0) && hit;
  endfunction

  function automatic bit ref_stall();
    return !rst && !m_in_lu && ref_hazard();
  endfunction

  function automatic void ref_op(int i, output logic [31:0] d, output logic [1:0] s);
    logic [4:0] rs;
    rs = ex_rs[i*REGW +: REGW];
    d  = ex_rf_data[i*XLEN +: XLEN];
    s  = 2'b00;
    if (rs != 0) begin
      if (exmem_valid && exmem_rd == rs) begin
        d = exmem_data; s = 2'b10;
      end else if (memwb_valid && memwb_rd == rs) begin
        d = memwb_data; s = 2'b01;
      end else if (cap_idx[rs] > rst_idx && (sh - cap_idx[rs]) < HIST) begin
        d = cap_data[rs]; s = 2'b11;
      end
    end
  endfunction

  function automatic bit ref_fwd_err_event();
    bit e = 0;
    for (int i = 0; i < NSRC; i++) begin
      logic [4:0] rs;
      rs = ex_rs[i*REGW +: REGW];
      if (rs != 0 && exmem_valid && exmem_rd == rs) e = 1;
    end
    return e && exmem_is_load;
  endfunction

  task automatic model_step();
    bit st, fe;
    if (rst) begin
      m_in_lu = 0; m_cnt = 0; m_err = 0; rst_idx = sh;
    end else if (!mem_busy) begin
      st = ref_stall();
      fe = ref_fwd_err_event();
      if (st && m_cnt < SAT) m_cnt++;
      if (fe) m_err = 1;
      m_in_lu = st;
      sh++;
      if (memwb_valid && memwb_rd != 0) begin
        cap_idx[memwb_rd]  = sh;
        cap_data[memwb_rd] = memwb_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all(string tag);
    logic [31:0] d;
    logic [1:0]  s;
    for (int i = 0; i < NSRC; i++) begin
      ref_op(i, d, s);
      chk($sformatf("%s opnd%0d", tag, i), 64'(ex_opnd[i*XLEN +: XLEN]), 64'(d));
      chk($sformatf("%s sel%0d", tag, i), 64'(ex_src_sel[i*2 +: 2]), 64'(s));
    end
    chk({tag, " stall_id"}, 64'(stall_id), 64'(ref_stall()));
    chk({tag, " bubble_ex"}, 64'(bubble_ex), 64'(ref_stall()));
    chk({tag, " fwd_err"}, 64'(fwd_err), 64'(m_err));
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic clear_inputs();
    mem_busy = 0; id_valid = 0; id_rs = '0; idex_valid = 0; idex_is_load = 0;
    idex_rd = '0; ex_rs = '0; ex_rf_data = '0; exmem_valid = 0; exmem_is_load = 0;
    exmem_rd = '0; exmem_data = '0; memwb_valid = 0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_load_hazard(logic [4:0] rd);
    id_valid = 1; id_rs = {5'd0, rd};
    idex_valid = 1; idex_is_load = 1; idex_rd = rd;
  endtask

  typedef struct {
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [4:0]  rs0, rs1;
    logic [31:0] e_op0, e_op1;
    logic [1:0]  e_s0, e_s1;
  } vec_t;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;

  initial begin
    vec_t vt [8];
    vt[0] = '{1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 3, 4, 32'hAAAA, RF1, 2'b10, 2'b00};
    vt[1] = '{1, 0, 32'hFFFF, 0, 0, 32'h0, 0, 0, RF0, RF1, 2'b00, 2'b00};
    vt[2] = '{0, 3, 32'hAAAA, 1, 3, 32'hBBBB, 3, 3, 32'hBBBB, 32'hBBBB, 2'b01, 2'b01};
    vt[3] = '{1, 2, 32'hCCCC, 1, 6, 32'hDDDD, 6, 2, 32'hDDDD, 32'hCCCC, 2'b01, 2'b10};
    vt[4] = '{1, 1, 32'h0101, 1, 0, 32'hEEEE, 0, 1, RF0, 32'h0101, 2'b00, 2'b10};
    vt[5] = '{0, 5, 32'h5A5A, 0, 5, 32'hA5A5, 5, 5, RF0, RF1, 2'b00, 2'b00};
    vt[6] = '{1, 31, 32'h3131, 1, 30, 32'h3030, 29, 31, RF0, 32'h3131, 2'b00, 2'b10};
    vt[7] = '{1, 8, 32'h0808, 1, 8, 32'h0909, 8, 30, 32'h0808, RF1, 2'b10, 2'b00};

    for (int r = 0; r < 32; r++) begin cap_idx[r] = 0; cap_data[r] = '0; end
    rst = 1;
    clear_inputs();
    #1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("reset stall_id", 64'(stall_id), 64'd0);
    chk("reset fwd_err", 64'(fwd_err), 64'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    $display("reset done: stall_cnt=%0d fwd_err=%0b", stall_cnt, fwd_err);

    // Vector table, held with mem_busy so history stays empty.
    for (int v = 0; v < 8; v++) begin
      clear_inputs();
      mem_busy = 1;
      ex_rf_data = {RF1, RF0};
      exmem_valid = vt[v].exv; exmem_rd = vt[v].exrd; exmem_data = vt[v].exd;
      memwb_valid = vt[v].wbv; memwb_rd = vt[v].wbrd; memwb_data = vt[v].wbd;
      ex_rs = {vt[v].rs1, vt[v].rs0};
      #1;
      chk($sformatf("vec%0d opnd0", v), 64'(ex_opnd[31:0]), 64'(vt[v].e_op0));
      chk($sformatf("vec%0d opnd1", v), 64'(ex_opnd[63:32]), 64'(vt[v].e_op1));
      chk($sformatf("vec%0d sel0", v), 64'(ex_src_sel[1:0]), 64'(vt[v].e_s0));
      chk($sformatf("vec%0d sel1", v), 64'(ex_src_sel[3:2]), 64'(vt[v].e_s1));
      $display("vec%0d rs=%0d/%0d opnd=%h/%h sel=%b/%b", v, vt[v].rs0, vt[v].rs1,
               ex_opnd[31:0], ex_opnd[63:32], ex_src_sel[1:0], ex_src_sel[3:2]);
      tick();
    end

    // History lifetime of a single retired write.
    clear_inputs();
    do_reset();
    memwb_valid = 1; memwb_rd = 7; memwb_data = 32'h1234;
    tick();
    memwb_valid = 0; ex_rs = {5'd7, 5'd0}; ex_rf_data = {32'h5555_5555, RF0};
    #1;
    chk("hist N+1 opnd1", 64'(ex_opnd[63:32]), 64'h1234);
    chk("hist N+1 sel1", 64'(ex_src_sel[3:2]), 64'b11);
    tick();
    chk("hist N+2 sel1", 64'(ex_src_sel[3:2]), 64'b11);
    tick();
    chk("hist N+3 opnd1", 64'(ex_opnd[63:32]), 64'h5555_5555);
    chk("hist N+3 sel1", 64'(ex_src_sel[3:2]), 64'b00);
    $display("history expiry: sel1=%b opnd1=%h", ex_src_sel[3:2], ex_opnd[63:32]);

    // Load-use: exactly one stall cycle.
    clear_inputs();
    do_reset();
    set_load_hazard(5'd5);
    #1;
    chk("lu stall_id", 64'(stall_id), 64'd1);
    chk("lu bubble_ex", 64'(bubble_ex), 64'd1);
    tick();
    chk("lu second stall_id", 64'(stall_id), 64'd0);
    chk("lu stall_cnt", 64'(stall_cnt), 64'd1);
    idex_valid = 0;
    tick();
    chk("lu after stall_cnt", 64'(stall_cnt), 64'd1);
    $display("load-use single stall: stall_cnt=%0d", stall_cnt);

    // Stall forced low during reset while forwarding stays live.
    set_load_hazard(5'd5);
    exmem_valid = 1; exmem_rd = 4; exmem_data = 32'h4444; ex_rs = {5'd0, 5'd4};
    rst = 1;
    #1;
    chk("rst stall_id", 64'(stall_id), 64'd0);
    chk("rst sel0", 64'(ex_src_sel[1:0]), 64'b10);
    tick();
    rst = 0;
    exmem_valid = 0;
    // Load-use under a 3-cycle hold.
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("busy%0d stall_id", c), 64'(stall_id), 64'd1);
      chk($sformatf("busy%0d stall_cnt", c), 64'(stall_cnt), 64'd0);
      tick();
    end
    mem_busy = 0;
    #1;
    chk("release stall_id", 64'(stall_id), 64'd1);
    tick();
    chk("release stall_cnt", 64'(stall_cnt), 64'd1);
    chk("release stall_id off", 64'(stall_id), 64'd0);
    $display("load-use under hold: stall_cnt=%0d", stall_cnt);

    // Reset while in LU_STALL returns to RUN.
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst from lu stall_id", 64'(stall_id), 64'd1);
    $display("reset from LU_STALL: stall_id=%0b", stall_id);

    // Illegal forward of a load result is sticky until reset.
    clear_inputs();
    do_reset();
    exmem_valid = 1; exmem_is_load = 1; exmem_rd = 9; exmem_data = 32'hDEAD_BEEF;
    ex_rs = {5'd0, 5'd9};
    #1;
    chk("ferr sel0", 64'(ex_src_sel[1:0]), 64'b10);
    chk("ferr opnd0", 64'(ex_opnd[31:0]), 64'hDEAD_BEEF);
    chk("ferr before", 64'(fwd_err), 64'd0);
    tick();
    exmem_valid = 0; exmem_is_load = 0;
    chk("ferr set", 64'(fwd_err), 64'd1);
    tick();
    chk("ferr held", 64'(fwd_err), 64'd1);
    do_reset();
    chk("ferr cleared", 64'(fwd_err), 64'd0);
    $display("fwd_err sticky and cleared by reset");

    // Saturation of the stall counter.
    clear_inputs();
    do_reset();
    set_load_hazard(5'd12);
    for (int c = 0; c < 38; c++) tick();
    chk("sat below", 64'(stall_cnt), 64'(SAT - 16'd1));
    for (int c = 0; c < 12; c++) tick();
    chk("sat ceiling", 64'(stall_cnt), 64'(SAT));
    $display("saturation: stall_cnt=%0d", stall_cnt);

    // Randomized traffic against the model.
    clear_inputs();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst           = ($urandom_range(0, 49) == 0);
      mem_busy      = ($urandom_range(0, 4) == 0);
      id_valid      = $urandom_range(0, 1);
      id_rs         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      idex_valid    = $urandom_range(0, 1);
      idex_is_load  = $urandom_range(0, 1);
      idex_rd       = 5'($urandom_range(0, 7));
      ex_rs         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rf_data    = {$urandom, $urandom};
      exmem_valid   = $urandom_range(0, 1);
      exmem_is_load = ($urandom_range(0, 3) == 0);
      exmem_rd      = 5'($urandom_range(0, 7));
      exmem_data    = $urandom;
      memwb_valid   = $urandom_range(0, 1);
      memwb_rd      = 5'($urandom_range(0, 7));
      memwb_data    = $urandom;
      #1;
      check_all($sformatf("rnd%0d", c));
      $display("rnd%0d rs=%0d/%0d sel=%b/%b stall=%0b cnt=%0d ferr=%0b", c,
               ex_rs[4:0], ex_rs[9:5], ex_src_sel[1:0], ex_src_sel[3:2],
               stall_id, stall_cnt, fwd_err);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bypass_network.md
BYPASS_NETWORK -- requirements
Module: bypass_network

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width.
REQ-002 The block SHALL have parameter NSRC, default 2, meaning the number of EX-stage source operands resolved in parallel.
REQ-003 The block SHALL have parameter HIST, default 2 (range 1..4), meaning the number of retired-writeback history entries kept for forwarding.
REQ-004 The block SHALL have parameter REGW, default 5, meaning the register-address width.
REQ-005 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous reset, active-high.
  mem_busy  in  1  pipeline-wide hold; all state frozen while high.
  id_valid  in  1  decode-stage instruction valid.
  id_rs  in  NSRC*REGW  decode-stage source addresses.
  idex_valid, idex_is_load  in  1 each  EX-stage instruction valid; EX instruction is a load.
  idex_rd  in  REGW  EX-stage destination.
  ex_rs  in  NSRC*REGW  EX-stage source addresses.
  ex_rf_data  in  NSRC*XLEN  register-file operands latched in ID/EX.
  exmem_valid, exmem_is_load  in  1 each  MEM-stage valid; MEM-stage instruction is a load.
  exmem_rd  in  REGW  MEM-stage destination.
  exmem_data  in  XLEN  MEM-stage ALU result.
  memwb_valid  in  1  WB-stage valid write.
  memwb_rd  in  REGW  WB-stage destination.
  memwb_data  in  XLEN  WB-stage result.
  ex_opnd  out  NSRC*XLEN  resolved operands.
  ex_src_sel  out  NSRC*2  per-operand source: 00 ID/EX, 10 EX/MEM, 01 MEM/WB, 11 history.
  stall_id  out  1  hold PC and IF/ID.
  bubble_ex  out  1  insert a NOP into ID/EX.
  fwd_err  out  1  sticky illegal-forward flag.
  stall_cnt  out  16  saturating load-use stall counter.

Function
REQ-006 Each operand i SHALL be resolved combinationally, at fixed priority: EX/MEM match, then MEM/WB match, then newest-to-oldest valid history match, else ex_rf_data[i].
REQ-007 A match SHALL require the source valid, rd equal to ex_rs[i], and ex_rs[i] != 0; register x0 SHALL always select ID/EX with sel 00.
REQ-008 The history buffer SHALL be a HIST-entry shift register of {valid, rd, data}. On each clk edge with mem_busy=0, it SHALL shift in {memwb_valid && memwb_rd!=0, memwb_rd, memwb_data} at entry 0 and drop the oldest entry.
REQ-009 The load-use FSM SHALL have exactly two states, RUN and LU_STALL.
REQ-010 The load-use hazard SHALL be defined as: id_valid && idex_valid && idex_is_load && idex_rd!=0 && (some id_rs[j]==idex_rd).
REQ-011 In RUN with a hazard present, stall_id and bubble_ex SHALL both be 1 in the same cycle, and the next state SHALL be LU_STALL.
REQ-012 In LU_STALL, stall_id and bubble_ex SHALL be 0, the hazard SHALL NOT be evaluated, and the next state SHALL be RUN, giving exactly one stall cycle per load.
REQ-013 While mem_busy=1, the FSM state, history, fwd_err and stall_cnt SHALL hold, and stall_id/bubble_ex SHALL keep their combinational values.
REQ-014 stall_cnt SHALL increment by 1 on each non-held clk edge where stall_id=1, and SHALL saturate at 16'hFFFF.
REQ-015 fwd_err SHALL set on a clk edge where any operand resolves to EX/MEM while exmem_is_load=1, and SHALL stay set until rst; the selected data in that case is still exmem_data.
REQ-016 When EX/MEM and MEM/WB both match the same rs, EX/MEM SHALL win; when two history entries match, the newer entry SHALL win.

Reset
REQ-017 While rst=1 at a clk edge: state SHALL go to RUN, all history valid bits SHALL clear, stall_cnt SHALL go to 0, and fwd_err SHALL go to 0; rst SHALL override mem_busy.
REQ-018 During the rst cycle, stall_id and bubble_ex SHALL be forced to 0, while operand resolution SHALL stay combinational.
REQ-019 A reset asserted in LU_STALL SHALL return the FSM to RUN with no further stall cycle.

Verification
REQ-020 Scenario: exmem rd=3 data=0xAAAA, memwb rd=3 data=0xBBBB, ex_rs0=3 -> ex_opnd0=0xAAAA, sel0=10.
REQ-021 Scenario: memwb rd=7 data=0x1234 at cycle N, no later writes to rd 7, ex_rs1=7 at cycle N+1 -> ex_opnd1=0x1234, sel1=11; at cycle N+HIST+1 -> ex_rf_data1, sel1=00.
REQ-022 Scenario: ex_rs0=0 with exmem rd=0 data=0xFFFF -> ex_opnd0=ex_rf_data0, sel0=00.
REQ-023 Scenario: load with idex_rd=5 and id_rs0=5 -> stall_id=bubble_ex=1 for exactly one cycle, stall_cnt becomes 1; same stimulus with mem_busy=1 for 3 cycles -> stall_id stays 1 for those cycles while stall_cnt holds at 0 until release.
REQ-024 Scenario: exmem_is_load=1 with exmem_rd=9 and ex_rs0=9 -> fwd_err=1 from the next cycle and held; rst then clears it to 0.
REQ-025 Scenario: 65540 consecutive hazard pairs -> stall_cnt=0xFFFF with no wrap.
